// File: rtl/pulse_fsm_dac.sv
`timescale 1ns/1ps
// pulse_fsm_dac
// Trigger-driven pulse sequencer with a two-channel DAC code mapper.
// Each rising edge of the slow trigger s runs LEAD -> PULSE -> PH_A -> PH_B -> IDLE.
// The gate outputs L/P/A/B are registered one-hot decodes of the state.
// While P is high the DAC carries AMP_A/AMP_B. Otherwise it carries IDLE_CODE.
// The DAC codes lag P by one clock.
// Optional build macro: PULSE_RETRIG_EN. When it is defined, a trigger outside IDLE
// restarts the sequence at LEAD. When it is undefined, such a trigger is discarded.
//
//  state | meaning
//  ------+----------------------------------------------
//  IDLE  | waiting for a synchronized rising edge of s
//  LEAD  | L high for LEAD_CYCLES clocks
//  PULSE | P high for PULSE_CYCLES clocks
//  PH_A  | A high for A_CYCLES clocks
//  PH_B  | B high for B_CYCLES clocks, then back to IDLE

module pulse_fsm_dac #(
    parameter int                   DAC_WIDTH    = 14,
    parameter int                   LEAD_CYCLES  = 2,
    parameter int                   PULSE_CYCLES = 4,
    parameter int                   A_CYCLES     = 4,
    parameter int                   B_CYCLES     = 4,
    parameter logic [DAC_WIDTH-1:0] IDLE_CODE    = 14'h2000,
    parameter logic [DAC_WIDTH-1:0] AMP_A        = 14'h3FFF,
    parameter logic [DAC_WIDTH-1:0] AMP_B        = 14'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s,
    output logic                 P,
    output logic                 L,
    output logic                 A,
    output logic                 B,
    output logic [DAC_WIDTH-1:0] DAC_A,
    output logic [DAC_WIDTH-1:0] DAC_B
);

    // A zero-length phase would skip a gate entirely, so every phase lasts at least one clock.
    localparam int LEAD_EFF  = (LEAD_CYCLES  < 1) ? 1 : LEAD_CYCLES;
    localparam int PULSE_EFF = (PULSE_CYCLES < 1) ? 1 : PULSE_CYCLES;
    localparam int A_EFF     = (A_CYCLES     < 1) ? 1 : A_CYCLES;
    localparam int B_EFF     = (B_CYCLES     < 1) ? 1 : B_CYCLES;

    localparam int MAX_LP  = (LEAD_EFF > PULSE_EFF) ? LEAD_EFF : PULSE_EFF;
    localparam int MAX_AB  = (A_EFF > B_EFF) ? A_EFF : B_EFF;
    localparam int MAX_CYC = (MAX_LP > MAX_AB) ? MAX_LP : MAX_AB;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The counter is loaded with (cycles - 1) on entry.
    // The state advances on the clock where the counter reads zero.
    localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'(LEAD_EFF - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_EFF - 1);
    localparam logic [CNT_W-1:0] A_LOAD     = CNT_W'(A_EFF - 1);
    localparam logic [CNT_W-1:0] B_LOAD     = CNT_W'(B_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        PULSE = 3'd2,
        PH_A  = 3'd3,
        PH_B  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1, s2, s2_d;
    logic             trig;

    // Two-flop synchronizer for the asynchronous trigger, plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= s;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // s2_d clears in reset, so a trigger already high at reset release counts as one edge.
    assign trig = s2 & ~s2_d;

    // State and down-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic: each active phase counts down, then hands over to the next phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = LEAD;
                    cnt_d   = LEAD_LOAD;
                end
            end
            LEAD: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = PH_A;
                    cnt_d   = A_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PH_A: begin
                if (cnt_q == '0) begin
                    state_d = PH_B;
                    cnt_d   = B_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PH_B: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef PULSE_RETRIG_EN
        // A new edge mid-sequence restarts at LEAD with a full count. An in-flight pulse is cut short.
        if (trig && (state_q != IDLE)) begin
            state_d = LEAD;
            cnt_d   = LEAD_LOAD;
        end
`endif
    end

    // Gates are registered from the next state, so they change with the state and cannot glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            L <= 1'b0;
            P <= 1'b0;
            A <= 1'b0;
            B <= 1'b0;
        end else begin
            L <= (state_d == LEAD);
            P <= (state_d == PULSE);
            A <= (state_d == PH_A);
            B <= (state_d == PH_B);
        end
    end

    // The DAC stage follows the registered P, so the codes trail the gate by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DAC_A <= IDLE_CODE;
            DAC_B <= IDLE_CODE;
        end else begin
            DAC_A <= P ? AMP_A : IDLE_CODE;
            DAC_B <= P ? AMP_B : IDLE_CODE;
        end
    end

endmodule

// File: tb/tb_pulse_fsm_dac.sv
`timescale 1ns/1ps
// Testbench for pulse_fsm_dac.
// The main instance uses the default parameters.
// A second instance uses LEAD_CYCLES=0 and PULSE_CYCLES=1.
// Expected traces are segment tables, expanded into one expected record per clock.
// Offset i is the clock edge at which the trigger level is first sampled, plus i.
module tb_pulse_fsm_dac;

    localparam logic [13:0] IC  = 14'h2000;
    localparam logic [13:0] AMA = 14'h3FFF;
    localparam logic [13:0] AMB = 14'h0000;
    localparam int          TR  = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s   = 1'b0;
    logic        p, l, a, b;
    logic [13:0] dac_a, dac_b;
    logic        pm, lm, am, bm;
    logic [13:0] dac_am, dac_bm;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        s;
        int          n;
        logic        l, p, a, b;
        logic [13:0] da, db;
    } seg_t;

    seg_t        segs[8];
    logic [31:0] exp_tr[TR];
    logic        s_tr[TR];
`ifdef PULSE_RETRIG_EN
    seg_t        segs_rt[11];
    logic [31:0] exp_rt[TR];
`endif

    pulse_fsm_dac u_dut (
        .clk(clk), .rst(rst), .s(s),
        .P(p), .L(l), .A(a), .B(b),
        .DAC_A(dac_a), .DAC_B(dac_b)
    );

    pulse_fsm_dac #(.LEAD_CYCLES(0), .PULSE_CYCLES(1)) u_dut_min (
        .clk(clk), .rst(rst), .s(s),
        .P(pm), .L(lm), .A(am), .B(bm),
        .DAC_A(dac_am), .DAC_B(dac_bm)
    );

    always #2 clk = ~clk;

    wire [31:0] obs     = {l, p, a, b, dac_a, dac_b};
    wire [31:0] obs_min = {lm, pm, am, bm, dac_am, dac_bm};

    function automatic logic [31:0] pk(input logic l_v, input logic p_v, input logic a_v,
                                       input logic b_v, input logic [13:0] da, input logic [13:0] db);
        return {l_v, p_v, a_v, b_v, da, db};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got LPAB=%b dac=%h/%h, expected LPAB=%b dac=%h/%h",
                     name, idx, got[31:28], got[27:14], got[13:0], exp[31:28], exp[27:14], exp[13:0]);
        end
    endtask

    // Drive s, advance one clock, then sample 1 ns after the edge.
    task automatic step(input logic s_v);
        s = s_v;
        @(posedge clk);
        #1;
    endtask

    task automatic run_std_trace(input string name);
        for (int i = 0; i < TR; i++) begin
            step(s_tr[i]);
            check(name, i, obs, exp_tr[i]);
        end
    endtask

    initial begin
        // Default sequence: L for 2 clocks, then P 4, A 4, B 4.
        // The DAC codes trail P by one clock.
        segs[0] = '{s:1'b1, n:2, l:0, p:0, a:0, b:0, da:IC,  db:IC};
        segs[1] = '{s:1'b1, n:2, l:1, p:0, a:0, b:0, da:IC,  db:IC};
        segs[2] = '{s:1'b1, n:1, l:0, p:1, a:0, b:0, da:IC,  db:IC};
        segs[3] = '{s:1'b1, n:3, l:0, p:1, a:0, b:0, da:AMA, db:AMB};
        segs[4] = '{s:1'b1, n:1, l:0, p:0, a:1, b:0, da:AMA, db:AMB};
        segs[5] = '{s:1'b1, n:3, l:0, p:0, a:1, b:0, da:IC,  db:IC};
        segs[6] = '{s:1'b0, n:4, l:0, p:0, a:0, b:1, da:IC,  db:IC};
        segs[7] = '{s:1'b0, n:9, l:0, p:0, a:0, b:0, da:IC,  db:IC};
        begin
            int idx = 0;
            for (int g = 0; g < 8; g++)
                for (int k = 0; k < segs[g].n; k++) begin
                    exp_tr[idx] = pk(segs[g].l, segs[g].p, segs[g].a, segs[g].b, segs[g].da, segs[g].db);
                    s_tr[idx]   = segs[g].s;
                    idx++;
                end
        end
`ifdef PULSE_RETRIG_EN
        // Glitch sampled at offset 5 (during P). L comes back at offset 7 and the sequence runs again in full.
        segs_rt[0]  = '{s:1'b0, n:2, l:0, p:0, a:0, b:0, da:IC,  db:IC};
        segs_rt[1]  = '{s:1'b0, n:2, l:1, p:0, a:0, b:0, da:IC,  db:IC};
        segs_rt[2]  = '{s:1'b0, n:1, l:0, p:1, a:0, b:0, da:IC,  db:IC};
        segs_rt[3]  = '{s:1'b0, n:2, l:0, p:1, a:0, b:0, da:AMA, db:AMB};
        segs_rt[4]  = '{s:1'b0, n:1, l:1, p:0, a:0, b:0, da:AMA, db:AMB};
        segs_rt[5]  = '{s:1'b0, n:1, l:1, p:0, a:0, b:0, da:IC,  db:IC};
        segs_rt[6]  = '{s:1'b0, n:1, l:0, p:1, a:0, b:0, da:IC,  db:IC};
        segs_rt[7]  = '{s:1'b0, n:3, l:0, p:1, a:0, b:0, da:AMA, db:AMB};
        segs_rt[8]  = '{s:1'b0, n:1, l:0, p:0, a:1, b:0, da:AMA, db:AMB};
        segs_rt[9]  = '{s:1'b0, n:3, l:0, p:0, a:1, b:0, da:IC,  db:IC};
        segs_rt[10] = '{s:1'b0, n:8, l:0, p:0, a:0, b:1, da:IC,  db:IC};
        begin
            int idx = 0;
            for (int g = 0; g < 11; g++)
                for (int k = 0; k < segs_rt[g].n; k++) begin
                    if (idx < TR) begin
                        if (idx >= 21)
                            exp_rt[idx] = pk(1'b0, 1'b0, 1'b0, 1'b0, IC, IC);
                        else
                            exp_rt[idx] = pk(segs_rt[g].l, segs_rt[g].p, segs_rt[g].a, segs_rt[g].b,
                                             segs_rt[g].da, segs_rt[g].db);
                    end
                    idx++;
                end
        end
`endif

        // Reset held low while s toggles: every output stays at its reset value.
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(i[0] ? 1'b0 : 1'b1);
            check("reset_hold", i, obs, pk(0, 0, 0, 0, IC, IC));
        end
        step(1'b0);
        step(1'b0);
        step(1'b0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check("idle_after_release", i, obs, pk(0, 0, 0, 0, IC, IC));
        end

        // One sequence per trigger period, five periods back to back.
        for (int t = 0; t < 5; t++)
            run_std_trace($sformatf("seq%0d", t));

        // One-clock glitch on s while P is high.
        for (int i = 0; i < TR; i++) begin
            step((i == 0) || (i == 5));
`ifdef PULSE_RETRIG_EN
            check("glitch_retrig", i, obs, exp_rt[i]);
`else
            check("glitch_ignored", i, obs, exp_tr[i]);
`endif
        end

        // Reset asserted mid-PH_A clears the outputs at once, without waiting for a clock.
        for (int i = 0; i < 10; i++) begin
            step(i == 0);
            check("pre_reset", i, obs, exp_tr[i]);
        end
        #1 rst = 1'b0;
        #0.5;
        check("async_reset", 0, obs, pk(0, 0, 0, 0, IC, IC));
        step(1'b0);
        step(1'b0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            check("no_resume", i, obs, pk(0, 0, 0, 0, IC, IC));
        end
        run_std_trace("fresh_edge");

        // LEAD_CYCLES=0 and PULSE_CYCLES=1: L and P are each high for exactly one clock.
        for (int i = 0; i < 16; i++) begin
            logic [13:0] dv;
            step(i == 0);
            dv = (i == 4) ? AMA : IC;
            check("min_params", i, obs_min,
                  pk(i == 2, i == 3, (i >= 4) && (i <= 7), (i >= 8) && (i <= 11),
                     dv, (i == 4) ? AMB : IC));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Backstop so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, got %0d checks", n_chk);
        $fatal(1, "timeout");
    end

endmodule
